// File: rtl/rf_wb_arbiter_if.sv
// Write-back arbiter bus: WB and MDU write requests, the GPR and HI/LO write ports, and the decode hazard query.
// The slave modport is the arbiter side. The master modport is the pipeline and register-file side.
interface rf_wb_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
);
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              wb_hilo_we;
  logic [63:0]       wb_hilo_data;
  logic              mdu_valid;
  logic              mdu_ready;
  logic              mdu_rf_we;
  logic [ADDR_W-1:0] mdu_addr;
  logic [WIDTH-1:0]  mdu_data;
  logic              mdu_hilo_we;
  logic [63:0]       mdu_hilo_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_data;
  logic              hilo_we;
  logic [63:0]       hilo_data;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;
  logic              q_hilo_hit;
  logic              pend_empty;

  modport slave (
    input  wb_we, wb_addr, wb_data, wb_hilo_we, wb_hilo_data,
    input  mdu_valid, mdu_rf_we, mdu_addr, mdu_data, mdu_hilo_we, mdu_hilo_data,
    input  q_addr,
    output mdu_ready, rf_we, rf_addr, rf_data, hilo_we, hilo_data,
    output q_hit, q_hilo_hit, pend_empty
  );

  modport master (
    output wb_we, wb_addr, wb_data, wb_hilo_we, wb_hilo_data,
    output mdu_valid, mdu_rf_we, mdu_addr, mdu_data, mdu_hilo_we, mdu_hilo_data,
    output q_addr,
    input  mdu_ready, rf_we, rf_addr, rf_data, hilo_we, hilo_data,
    input  q_hit, q_hilo_hit, pend_empty
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the GPR and HI/LO write ports between WB (always wins) and a queued MDU result stream.
// Optional same-cycle MDU bypass into an empty queue: define RF_WB_ARB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 2
) (
  input  logic            clk,
  input  logic            aresetn,
  rf_wb_arbiter_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              rf_we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              hilo_we;
    logic [63:0]       hilo_data;
  } entry_t;

  entry_t            mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;

  entry_t            head_s;
  entry_t            in_s;
  logic              in_rf_we_s;
  logic              empty_s;
  logic              full_s;
  logic              drain_s;
  logic              byp_s;
  logic              push_s;
  logic              src_rf_we_s;
  logic              src_hilo_we_s;
  logic [ADDR_W-1:0] src_addr_s;
  logic [WIDTH-1:0]  src_data_s;
  logic [63:0]       src_hilo_data_s;
  logic              q_hit_s;
  logic              q_hilo_hit_s;
  logic [PTR_W-1:0]  off_s;
  logic              vld_s;

  // Queued entries are always older than the concurrent WB write, so WB kills matching flags.
  function automatic entry_t cancel_entry(input entry_t e, input logic gw,
                                          input logic [ADDR_W-1:0] ga, input logic hw);
    entry_t r;
    r = e;
    if (gw && (e.addr == ga)) r.rf_we = 1'b0;
    if (hw) r.hilo_we = 1'b0;
    return r;
  endfunction

  // Queue status, drain decision, optional bypass and enqueue image.
  always_comb begin
    empty_s    = (count_r == {CNT_W{1'b0}});
    full_s     = (count_r == CNT_W'(DEPTH));
    head_s     = mem_r[rd_ptr_r];
    in_rf_we_s = bus.mdu_rf_we && (bus.mdu_addr != {ADDR_W{1'b0}});
    drain_s    = !empty_s && (!head_s.rf_we || !bus.wb_we) && (!head_s.hilo_we || !bus.wb_hilo_we);
`ifdef RF_WB_ARB_BYPASS_EN
    byp_s      = empty_s && bus.mdu_valid && (!in_rf_we_s || !bus.wb_we)
                 && (!bus.mdu_hilo_we || !bus.wb_hilo_we);
`else
    byp_s      = 1'b0;
`endif
    push_s     = bus.mdu_valid && !full_s && !byp_s;
    in_s       = cancel_entry({in_rf_we_s, bus.mdu_addr, bus.mdu_data, bus.mdu_hilo_we, bus.mdu_hilo_data},
                              bus.wb_we, bus.wb_addr, bus.wb_hilo_we);
  end

  // Secondary write source: the queue head, or the bypassed MDU result.
  always_comb begin
    src_rf_we_s   = (drain_s && head_s.rf_we) || (byp_s && in_rf_we_s);
    src_hilo_we_s = (drain_s && head_s.hilo_we) || (byp_s && bus.mdu_hilo_we);
    if (byp_s) begin
      src_addr_s      = bus.mdu_addr;
      src_data_s      = bus.mdu_data;
      src_hilo_data_s = bus.mdu_hilo_data;
    end else begin
      src_addr_s      = head_s.addr;
      src_data_s      = head_s.data;
      src_hilo_data_s = head_s.hilo_data;
    end
  end

  // Hazard query over the registered queue contents only.
  always_comb begin
    q_hit_s      = 1'b0;
    q_hilo_hit_s = 1'b0;
    off_s        = {PTR_W{1'b0}};
    vld_s        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s        = PTR_W'(i) - rd_ptr_r;
      vld_s        = (CNT_W'(off_s) < count_r);
      q_hit_s      = q_hit_s | (vld_s & mem_r[i].rf_we & (mem_r[i].addr == bus.q_addr));
      q_hilo_hit_s = q_hilo_hit_s | (vld_s & mem_r[i].hilo_we);
    end
  end

  // Port mux and status outputs; everything is forced quiet while reset is asserted.
  always_comb begin
    bus.rf_we      = 1'b0;
    bus.rf_addr    = {ADDR_W{1'b0}};
    bus.rf_data    = {WIDTH{1'b0}};
    bus.hilo_we    = 1'b0;
    bus.hilo_data  = 64'h0;
    bus.mdu_ready  = 1'b0;
    bus.q_hit      = 1'b0;
    bus.q_hilo_hit = 1'b0;
    bus.pend_empty = 1'b1;
    if (!aresetn) begin
      bus.pend_empty = 1'b1;
    end else begin
      bus.mdu_ready  = !full_s;
      bus.q_hit      = q_hit_s;
      bus.q_hilo_hit = q_hilo_hit_s;
      bus.pend_empty = empty_s;
      if (bus.wb_we) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = bus.wb_addr;
        bus.rf_data = bus.wb_data;
      end else if (src_rf_we_s) begin
        bus.rf_we   = 1'b1;
        bus.rf_addr = src_addr_s;
        bus.rf_data = src_data_s;
      end else begin
        bus.rf_we   = 1'b0;
      end
      if (bus.wb_hilo_we) begin
        bus.hilo_we   = 1'b1;
        bus.hilo_data = bus.wb_hilo_data;
      end else if (src_hilo_we_s) begin
        bus.hilo_we   = 1'b1;
        bus.hilo_data = src_hilo_data_s;
      end else begin
        bus.hilo_we   = 1'b0;
      end
    end
  end

  // Pending FIFO: cancellation on every edge, push at tail, whole-entry pop at head.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= cancel_entry(mem_r[i], bus.wb_we, bus.wb_addr, bus.wb_hilo_we);
      end
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (drain_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected port writes go into scoreboard queues and a negedge monitor pops them.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.WIDTH(32), .ADDR_W(7)) bus ();
  rf_wb_arbiter #(.WIDTH(32), .ADDR_W(7), .DEPTH(2)) dut (.clk(clk), .aresetn(aresetn), .bus(bus));

  typedef struct { logic [6:0] addr; logic [31:0] data; } gpr_t;
  gpr_t        exp_gpr [$];
  logic [63:0] exp_hilo [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every port write must match the next expected write.
  always @(negedge clk) begin
    gpr_t e;
    if (bus.rf_we === 1'b1) begin
      if (exp_gpr.size() == 0) begin
        checks++; errors++;
        $display("FAIL gpr_unexpected: actual write addr %0d data %0h, required no write", bus.rf_addr, bus.rf_data);
      end else begin
        e = exp_gpr.pop_front();
        chk("gpr_addr", 64'(bus.rf_addr), 64'(e.addr));
        chk("gpr_data", 64'(bus.rf_data), 64'(e.data));
      end
    end
    if (bus.hilo_we === 1'b1) begin
      if (exp_hilo.size() == 0) begin
        checks++; errors++;
        $display("FAIL hilo_unexpected: actual write %0h, required no write", bus.hilo_data);
      end else begin
        chk("hilo_data", bus.hilo_data, exp_hilo.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    bus.wb_we = 1'b0;         bus.wb_addr = 7'd0;       bus.wb_data = 32'h0;
    bus.wb_hilo_we = 1'b0;    bus.wb_hilo_data = 64'h0;
    bus.mdu_valid = 1'b0;     bus.mdu_rf_we = 1'b0;     bus.mdu_addr = 7'd0;
    bus.mdu_data = 32'h0;     bus.mdu_hilo_we = 1'b0;   bus.mdu_hilo_data = 64'h0;
    bus.q_addr = 7'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic exp_rf(input logic [6:0] a, input logic [31:0] d);
    gpr_t e;
    e.addr = a;
    e.data = d;
    exp_gpr.push_back(e);
  endtask

  task automatic wb(input logic [6:0] a, input logic [31:0] d);
    bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    exp_rf(a, d);
  endtask

  task automatic wbh(input logic [63:0] d);
    bus.wb_hilo_we = 1'b1; bus.wb_hilo_data = d;
    exp_hilo.push_back(d);
  endtask

  task automatic mdu(input logic rfw, input logic [6:0] a, input logic [31:0] d,
                     input logic hw, input logic [63:0] hd);
    bus.mdu_valid = 1'b1; bus.mdu_rf_we = rfw; bus.mdu_addr = a; bus.mdu_data = d;
    bus.mdu_hilo_we = hw; bus.mdu_hilo_data = hd;
  endtask

  initial begin
    aresetn = 1'b0;
    idle_inputs();
    bus.wb_we = 1'b1; bus.wb_addr = 7'd3; bus.wb_data = 32'h77;
    #2;
    chk("rst_rf_we", bus.rf_we, 1'b0);
    chk("rst_hilo_we", bus.hilo_we, 1'b0);
    chk("rst_pend_empty", bus.pend_empty, 1'b1);
    chk("rst_mdu_ready", bus.mdu_ready, 1'b0);
    cyc(); cyc();
    aresetn = 1'b1;
    #1 chk("idle_ready", bus.mdu_ready, 1'b1);

    // Simple push, written the next cycle
    cyc(); mdu(1'b1, 7'd5, 32'h1234, 1'b0, 64'h0);
    #1 chk("t1_ready", bus.mdu_ready, 1'b1);
    chk("t1_latency", bus.rf_we, 1'b0);
    cyc(); exp_rf(7'd5, 32'h1234);
    #1 chk("t1_pending", bus.pend_empty, 1'b0);
    cyc(); #1 chk("t1_empty", bus.pend_empty, 1'b1);

    // Entry held while WB owns the GPR port
    cyc(); mdu(1'b1, 7'd8, 32'h88, 1'b0, 64'h0); wb(7'd3, 32'h31);
    cyc(); wb(7'd3, 32'h32); bus.q_addr = 7'd8;
    #1 chk("t2_qhit_a", bus.q_hit, 1'b1);
    cyc(); wb(7'd3, 32'h33); bus.q_addr = 7'd8;
    #1 chk("t2_qhit_b", bus.q_hit, 1'b1);
    cyc(); exp_rf(7'd8, 32'h88);
    cyc(); bus.q_addr = 7'd8;
    #1 chk("t2_empty", bus.pend_empty, 1'b1);
    chk("t2_qhit_clr", bus.q_hit, 1'b0);

    // Younger WB write to the same GPR cancels the queued one
    cyc(); mdu(1'b1, 7'd9, 32'h99, 1'b0, 64'h0); wb(7'd3, 32'h41);
    cyc(); wb(7'd9, 32'hAA); bus.q_addr = 7'd9;
    #1 chk("t3_qhit_pre", bus.q_hit, 1'b1);
    cyc(); bus.q_addr = 7'd9;
    #1 chk("t3_qhit_post", bus.q_hit, 1'b0);
    chk("t3_dead_held", bus.pend_empty, 1'b0);
    cyc(); #1 chk("t3_empty", bus.pend_empty, 1'b1);

    // Full FIFO back-pressure and ordering
    cyc(); wb(7'd3, 32'h51); mdu(1'b1, 7'd10, 32'hA0, 1'b0, 64'h0);
    #1 chk("t4_ready0", bus.mdu_ready, 1'b1);
    cyc(); wb(7'd3, 32'h52); mdu(1'b1, 7'd11, 32'hB0, 1'b0, 64'h0);
    #1 chk("t4_ready1", bus.mdu_ready, 1'b1);
    cyc(); wb(7'd3, 32'h53); mdu(1'b1, 7'd12, 32'hC0, 1'b0, 64'h0);
    #1 chk("t4_full", bus.mdu_ready, 1'b0);
    cyc(); mdu(1'b1, 7'd12, 32'hC0, 1'b0, 64'h0); exp_rf(7'd10, 32'hA0);
    #1 chk("t4_full_drain", bus.mdu_ready, 1'b0);
    cyc(); mdu(1'b1, 7'd12, 32'hC0, 1'b0, 64'h0); exp_rf(7'd11, 32'hB0);
    #1 chk("t4_ready_again", bus.mdu_ready, 1'b1);
    cyc(); exp_rf(7'd12, 32'hC0);
    cyc(); #1 chk("t4_empty", bus.pend_empty, 1'b1);

    // HI/LO entry cancelled by a same-cycle WB HI/LO write
    cyc(); mdu(1'b0, 7'd0, 32'h0, 1'b1, 64'h1_0000_0002); wbh(64'hDEAD_BEEF_0000_0001);
    #1 chk("t5_qhilo_enq", bus.q_hilo_hit, 1'b0);
    cyc(); #1 chk("t5_qhilo_cancel", bus.q_hilo_hit, 1'b0);
    chk("t5_dead_held", bus.pend_empty, 1'b0);
    cyc(); #1 chk("t5_empty", bus.pend_empty, 1'b1);

    // HI/LO entry drains normally
    cyc(); mdu(1'b0, 7'd0, 32'h0, 1'b1, 64'h3_0000_0004);
    cyc(); exp_hilo.push_back(64'h3_0000_0004);
    #1 chk("t5_qhilo_hit", bus.q_hilo_hit, 1'b1);
    cyc(); #1 chk("t5_empty2", bus.pend_empty, 1'b1);

    // Dual-write entry blocked on GPR must not write HI/LO early
    cyc(); mdu(1'b1, 7'd20, 32'hCAFE, 1'b1, 64'h7_0000_0008); wb(7'd3, 32'h61);
    cyc(); wb(7'd3, 32'h62);
    #1 chk("t7_qhilo_held", bus.q_hilo_hit, 1'b1);
    cyc(); exp_rf(7'd20, 32'hCAFE); exp_hilo.push_back(64'h7_0000_0008);
    cyc(); #1 chk("t7_empty", bus.pend_empty, 1'b1);

    // Address 0 is enqueued without a GPR write
    cyc(); mdu(1'b1, 7'd0, 32'hEE, 1'b0, 64'h0);
    cyc(); bus.q_addr = 7'd0;
    #1 chk("t8_qhit_r0", bus.q_hit, 1'b0);
    chk("t8_dead_held", bus.pend_empty, 1'b0);
    cyc(); #1 chk("t8_empty", bus.pend_empty, 1'b1);

    // Reset with two entries queued
    cyc(); wb(7'd3, 32'h71); mdu(1'b1, 7'd13, 32'hD0, 1'b0, 64'h0);
    cyc(); wb(7'd3, 32'h72); mdu(1'b1, 7'd14, 32'hE0, 1'b0, 64'h0);
    cyc(); aresetn = 1'b0;
    bus.wb_we = 1'b1; bus.wb_addr = 7'd3; bus.wb_data = 32'h73;
    bus.wb_hilo_we = 1'b1; bus.wb_hilo_data = 64'h99;
    #1 chk("t6_pend_empty", bus.pend_empty, 1'b1);
    chk("t6_rf_we", bus.rf_we, 1'b0);
    chk("t6_hilo_we", bus.hilo_we, 1'b0);
    chk("t6_ready", bus.mdu_ready, 1'b0);
    cyc();
    cyc(); aresetn = 1'b1;
    #1 chk("t6_post_empty", bus.pend_empty, 1'b1);
    chk("t6_post_ready", bus.mdu_ready, 1'b1);
    cyc(); cyc(); cyc();
    #1 chk("exp_queues_drained", 64'(exp_gpr.size() + exp_hilo.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
